stepper_multi_ctrl: RTL

Parametrised N-axis successor to the single-axis stepper controller: accepts one command carrying a signed pulse count and pulse width per channel, then drives all channels' step/dir outputs from a common start, advancing only on `en` ticks. Adds a valid/ready command handshake, a synchronous all-channels-finished `done` pulse, per-channel zero-length handling and a global `abort`. Sits between the motion/command processor and the motor driver pins, clocked by the system clock and paced by a shared FreqDivider tick.

---
 rtl/stepper_pkg.sv | 33 +++
 rtl/stepper_channel.sv | 109 ++++++++++
 rtl/stepper_multi_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared types for the multi-axis stepper controller: channel/top FSM states
// and the signed-count to pulse-magnitude conversion.
package stepper_pkg;

  localparam int MAG_BITS = 32;

  typedef enum logic [2:0] {
    CH_IDLE = 3'd0,
    CH_ARM  = 3'd1,
    CH_HIGH = 3'd2,
    CH_LOW  = 3'd3,
    CH_FIN  = 3'd4
  } ch_state_e;

  typedef enum logic {
    TOP_IDLE = 1'b0,
    TOP_RUN  = 1'b1
  } top_state_e;

  // Caller zero-extends the count and truncates the result back to its width,
  // so the most negative count maps to 2^(W-1).
  function automatic logic [MAG_BITS-1:0] to_mag(input logic [MAG_BITS-1:0] v,
                                                 input logic neg);
    logic [MAG_BITS-1:0] r;
    if (neg) begin
      r = ~v + {{(MAG_BITS-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/stepper_channel.sv
// One stepper axis: loads count/width on start, then produces magnitude pulses
// of width en-ticks high and width en-ticks low; reports fin when exhausted.
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int PULSE_NUM_BITS   = 8,
  parameter int PULSE_WIDTH_BITS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        start_i,
  input  logic                        clear_i,
  input  logic [PULSE_NUM_BITS-1:0]   pulse_num_i,
  input  logic [PULSE_WIDTH_BITS-1:0] pulse_width_i,
  output logic                        out_o,
  output logic                        dir_o,
  output logic                        fin_o
);

  localparam logic [PULSE_NUM_BITS-1:0]   N_ZERO = {PULSE_NUM_BITS{1'b0}};
  localparam logic [PULSE_NUM_BITS-1:0]   N_ONE  = {{(PULSE_NUM_BITS-1){1'b0}}, 1'b1};
  localparam logic [PULSE_WIDTH_BITS-1:0] W_ZERO = {PULSE_WIDTH_BITS{1'b0}};
  localparam logic [PULSE_WIDTH_BITS-1:0] W_ONE  = {{(PULSE_WIDTH_BITS-1){1'b0}}, 1'b1};

  ch_state_e                   state_q;
  logic [PULSE_NUM_BITS-1:0]   cnt_q;
  logic [PULSE_WIDTH_BITS-1:0] width_q;
  logic [PULSE_WIDTH_BITS-1:0] timer_q;
  logic                        out_q;
  logic                        dir_q;
  logic [PULSE_NUM_BITS-1:0]   mag;

  assign mag   = PULSE_NUM_BITS'(to_mag(MAG_BITS'(pulse_num_i), pulse_num_i[PULSE_NUM_BITS-1]));
  assign out_o = out_q;
  assign dir_o = dir_q;
  assign fin_o = (state_q == CH_FIN);

  // Channel pulse FSM; clear_i drops out but keeps dir for the next command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CH_IDLE;
      cnt_q   <= N_ZERO;
      width_q <= W_ZERO;
      timer_q <= W_ZERO;
      out_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else if (clear_i) begin
      state_q <= CH_IDLE;
      cnt_q   <= N_ZERO;
      timer_q <= W_ZERO;
      out_q   <= 1'b0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (start_i) begin
            dir_q   <= pulse_num_i[PULSE_NUM_BITS-1];
            cnt_q   <= mag;
            width_q <= pulse_width_i;
            timer_q <= W_ZERO;
            state_q <= ((mag == N_ZERO) || (pulse_width_i == W_ZERO)) ? CH_FIN : CH_ARM;
          end
        end
        CH_ARM: begin
          if (en) begin
            out_q   <= 1'b1;
            timer_q <= W_ZERO;
            state_q <= CH_HIGH;
          end
        end
        CH_HIGH: begin
          if (en) begin
            if (timer_q == width_q - W_ONE) begin
              timer_q <= W_ZERO;
              out_q   <= 1'b0;
              state_q <= CH_LOW;
            end else begin
              timer_q <= timer_q + W_ONE;
            end
          end
        end
        CH_LOW: begin
          if (en) begin
            if (timer_q == width_q - W_ONE) begin
              timer_q <= W_ZERO;
              cnt_q   <= cnt_q - N_ONE;
              if (cnt_q == N_ONE) begin
                state_q <= CH_FIN;
              end else begin
                out_q   <= 1'b1;
                state_q <= CH_HIGH;
              end
            end else begin
              timer_q <= timer_q + W_ONE;
            end
          end
        end
        CH_FIN: begin
          state_q <= CH_FIN;
        end
        default: begin
          state_q <= CH_IDLE;
          out_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/stepper_multi_ctrl.sv
// N-axis stepper controller top: command handshake, abort, and a done pulse
// once every channel has reached FIN.
module stepper_multi_ctrl
  import stepper_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int PULSE_NUM_BITS   = 8,
  parameter int PULSE_WIDTH_BITS = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [NUM_CH*PULSE_NUM_BITS-1:0]   cmd_pulse_num,
  input  logic [NUM_CH*PULSE_WIDTH_BITS-1:0] cmd_pulse_width,
  input  logic                               abort,
  output logic [NUM_CH-1:0]                  out,
  output logic [NUM_CH-1:0]                  dir,
  output logic                               busy,
  output logic                               done
);

  top_state_e        state_q;
  logic              busy_q;
  logic              done_q;
  logic              ready_q;
  logic [NUM_CH-1:0] ch_fin;
  logic              accept;
  logic              all_fin;
  logic              clear_ch;

  assign accept   = (state_q == TOP_IDLE) && cmd_valid;
  assign all_fin  = &ch_fin;
  assign clear_ch = (state_q == TOP_RUN) && (abort || all_fin);

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    stepper_channel #(
      .PULSE_NUM_BITS  (PULSE_NUM_BITS),
      .PULSE_WIDTH_BITS(PULSE_WIDTH_BITS)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .start_i      (accept),
      .clear_i      (clear_ch),
      .pulse_num_i  (cmd_pulse_num[i*PULSE_NUM_BITS +: PULSE_NUM_BITS]),
      .pulse_width_i(cmd_pulse_width[i*PULSE_WIDTH_BITS +: PULSE_WIDTH_BITS]),
      .out_o        (out[i]),
      .dir_o        (dir[i]),
      .fin_o        (ch_fin[i])
    );
  end

  // Top FSM; abort outranks completion so an aborted run never reports done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= TOP_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        TOP_IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q <= TOP_RUN;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        TOP_RUN: begin
          if (abort) begin
            state_q <= TOP_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
          end else if (all_fin) begin
            state_q <= TOP_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            done_q <= 1'b0;
          end
        end
        default: begin
          state_q <= TOP_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
